// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty meter.
package pwm_pkg;

   localparam int CNT_W_DEF = 16;

   typedef logic [CNT_W_DEF-1:0] tick_cnt_t;

   localparam logic LEVEL_STUCK_HI = 1'b1;
   localparam logic LEVEL_STUCK_LO = 1'b0;

endpackage

// File: rtl/pwm_tick_gen.sv
// Free-running prescaler: tick_o is high for one clk in every PRESCALE clks.
module pwm_tick_gen #(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick_o
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] RELOAD = PW'(PRESCALE - 1);

   logic [PW-1:0] cnt_q;
   logic [PW-1:0] cnt_d;

   // Down-counter: terminal count at zero produces the tick and reloads.
   assign tick_o = (cnt_q == '0);

   always_comb begin
      cnt_d = tick_o ? RELOAD : cnt_q - PW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures period and high time of a PWM line in prescaled ticks and flags a
// stuck line when no rising edge arrives within TIMEOUT ticks.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | not armed; next rise only starts a period (after reset / stuck)
//   MEAS  | armed; next rise reports the period just completed
module pwm_duty_meter
   import pwm_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEF,
   parameter int PRESCALE = 4,
   parameter int TIMEOUT  = 60000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] period_o,
   output logic [CNT_W-1:0] high_o,
   output logic             valid_o,
   output logic             stuck_o,
   output logic             level_o
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_MEAS = 1'b1;

   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] SAT    = '1;

   logic             s1_q, s2_q, s3_q;
   logic [0:0]       state_q, state_d;
   logic             frozen_q, frozen_d;
   logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
   logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic             stuck_q, stuck_d;
   logic             level_q, level_d;
   logic             valid_q, valid_d;
   logic             tick;
   logic             rise;
   logic             to_hit;

   pwm_tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_o (tick)
   );

   assign rise   = s2_q & ~s3_q;
   // frozen_q marks the IDLE that follows a stuck report, so it fires only once
   assign to_hit = ~frozen_q & (per_cnt_q == TO_VAL);

   always_comb begin
      state_d   = state_q;
      frozen_d  = frozen_q;
      per_cnt_d = per_cnt_q;
      hi_cnt_d  = hi_cnt_q;
      period_d  = period_q;
      high_d    = high_q;
      stuck_d   = stuck_q;
      level_d   = level_q;
      valid_d   = 1'b0;

      if (rise) begin
         per_cnt_d = tick ? CNT_W'(1) : '0;
         hi_cnt_d  = (tick & s2_q) ? CNT_W'(1) : '0;
         frozen_d  = 1'b0;
         state_d   = ST_MEAS;
         if (state_q == ST_MEAS) begin
            period_d = per_cnt_q;
            high_d   = hi_cnt_q;
            stuck_d  = 1'b0;
            level_d  = 1'b0;
            valid_d  = 1'b1;
         end
      end else if (to_hit) begin
         period_d = '0;
         high_d   = '0;
         stuck_d  = 1'b1;
         level_d  = s2_q ? LEVEL_STUCK_HI : LEVEL_STUCK_LO;
         valid_d  = 1'b1;
         state_d  = ST_IDLE;
         frozen_d = 1'b1;
      end else if (tick && !frozen_q) begin
         if (per_cnt_q != SAT) per_cnt_d = per_cnt_q + CNT_W'(1);
         if (s2_q && (hi_cnt_q != SAT)) hi_cnt_d = hi_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         s3_q      <= 1'b0;
         state_q   <= ST_IDLE;
         frozen_q  <= 1'b0;
         per_cnt_q <= '0;
         hi_cnt_q  <= '0;
         period_q  <= '0;
         high_q    <= '0;
         stuck_q   <= 1'b0;
         level_q   <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         s1_q      <= pwm_in;
         s2_q      <= s1_q;
         s3_q      <= s2_q;
         state_q   <= state_d;
         frozen_q  <= frozen_d;
         per_cnt_q <= per_cnt_d;
         hi_cnt_q  <= hi_cnt_d;
         period_q  <= period_d;
         high_q    <= high_d;
         stuck_q   <= stuck_d;
         level_q   <= level_d;
         valid_q   <= valid_d;
      end
   end

   assign period_o = period_q;
   assign high_o   = high_q;
   assign stuck_o  = stuck_q;
   assign level_o  = level_q;
   assign valid_o  = valid_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter: two instances (16-bit/clk4/TIMEOUT 50 and
// 8-bit/clk1/TIMEOUT 254) with reports captured by a negedge monitor.
module tb_pwm_duty_meter;

   typedef struct {
      logic [31:0] per;
      logic [31:0] hi;
      logic        stuck;
      logic        level;
      int          cyc;
   } rep_t;

   logic        clk;
   logic        rst_n;
   logic        pwm_a, pwm_b;
   logic [15:0] period_a, high_a;
   logic        valid_a, stuck_a, level_a;
   logic [7:0]  period_b, high_b;
   logic        valid_b, stuck_b, level_b;

   int   cyc;
   int   checks;
   int   errors;
   int   dbl_a, dbl_b;
   logic prev_a, prev_b;
   rep_t q_a[$];
   rep_t q_b[$];

   pwm_duty_meter #(.CNT_W(16), .PRESCALE(4), .TIMEOUT(50)) dut_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .pwm_in   (pwm_a),
      .period_o (period_a),
      .high_o   (high_a),
      .valid_o  (valid_a),
      .stuck_o  (stuck_a),
      .level_o  (level_a)
   );

   pwm_duty_meter #(.CNT_W(8), .PRESCALE(1), .TIMEOUT(254)) dut_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .pwm_in   (pwm_b),
      .period_o (period_b),
      .high_o   (high_b),
      .valid_o  (valid_b),
      .stuck_o  (stuck_b),
      .level_o  (level_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      dbl_a  = 0;
      dbl_b  = 0;
      prev_a = 1'b0;
      prev_b = 1'b0;
   end

   always @(negedge clk) begin
      if (valid_a) begin
         q_a.push_back('{32'(period_a), 32'(high_a), stuck_a, level_a, cyc});
         if (prev_a) dbl_a <= dbl_a + 1;
      end
      if (valid_b) begin
         q_b.push_back('{32'(period_b), 32'(high_b), stuck_b, level_b, cyc});
         if (prev_b) dbl_b <= dbl_b + 1;
      end
      prev_a <= valid_a;
      prev_b <= valid_b;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_rep(input string tag, input bit use_b, input int idx,
                          input int per, input int hi, input bit st, input bit lv);
      rep_t e;
      int   n;
      n = use_b ? q_b.size() : q_a.size();
      if (idx < n) begin
         e = use_b ? q_b[idx] : q_a[idx];
         chk({tag, "_per"},   e.per, 32'(per));
         chk({tag, "_hi"},    e.hi, 32'(hi));
         chk({tag, "_stuck"}, 32'(e.stuck), 32'(st));
         chk({tag, "_level"}, 32'(e.level), 32'(lv));
      end else begin
         chk({tag, "_present"}, 32'(n), 32'(idx + 1));
      end
   endtask

   task automatic run_a(input int hi, input int lo, input int n, output int t0);
      @(negedge clk);
      t0 = cyc;
      for (int i = 0; i < n; i++) begin
         pwm_a = 1'b1;
         repeat (hi) @(negedge clk);
         pwm_a = 1'b0;
         repeat (lo) @(negedge clk);
      end
   endtask

   task automatic run_b(input int hi, input int lo, input int n, output int t0);
      @(negedge clk);
      t0 = cyc;
      for (int i = 0; i < n; i++) begin
         pwm_b = 1'b1;
         repeat (hi) @(negedge clk);
         pwm_b = 1'b0;
         repeat (lo) @(negedge clk);
      end
   endtask

   initial begin
      int t0;
      int m_a, m_b;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      pwm_a  = 1'b0;
      pwm_b  = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_period_a", 32'(period_a), 0);
      chk("rst_high_a",   32'(high_a), 0);
      chk("rst_valid_a",  32'(valid_a), 0);
      chk("rst_stuck_a",  32'(stuck_a), 0);
      chk("rst_level_a",  32'(level_a), 0);
      chk("rst_period_b", 32'(period_b), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: 40/60 clk x5 -> first rise silent, then 25/10 every 100 clk
      m_a = q_a.size();
      run_a(40, 60, 5, t0);
      chk("t1_count", 32'(q_a.size() - m_a), 4);
      for (int i = 0; i < 4; i++) chk_rep($sformatf("t1_r%0d", i), 1'b0, m_a + i, 25, 10, 1'b0, 1'b0);
      if (q_a.size() - m_a >= 4) begin
         chk("t1_latency", 32'(q_a[m_a].cyc - t0), 103);
         for (int i = 1; i < 4; i++)
            chk($sformatf("t1_spacing%0d", i), 32'(q_a[m_a + i].cyc - q_a[m_a + i - 1].cyc), 100);
      end

      // 2: duty change to 80/20 -> 25/10 for the last old period, then 25/20
      m_a = q_a.size();
      run_a(80, 20, 3, t0);
      chk("t2_count", 32'(q_a.size() - m_a), 3);
      chk_rep("t2_r0", 1'b0, m_a,     25, 10, 1'b0, 1'b0);
      chk_rep("t2_r1", 1'b0, m_a + 1, 25, 20, 1'b0, 1'b0);
      chk_rep("t2_r2", 1'b0, m_a + 2, 25, 20, 1'b0, 1'b0);

      // 3: held high -> one report for the last period, one stuck-high, no repeats
      m_a = q_a.size();
      @(negedge clk);
      pwm_a = 1'b1;
      repeat (1300) @(negedge clk);
      chk("t3_count", 32'(q_a.size() - m_a), 2);
      chk_rep("t3_r0",    1'b0, m_a,     25, 20, 1'b0, 1'b0);
      chk_rep("t3_stuck", 1'b0, m_a + 1, 0, 0, 1'b1, 1'b1);
      chk("t3_hold_stuck", 32'(stuck_a), 1);
      chk("t3_hold_level", 32'(level_a), 1);

      // 4: stuck low after a re-arm, then resume 40/60
      m_a = q_a.size();
      pwm_a = 1'b0;
      repeat (100) @(negedge clk);
      run_a(40, 60, 1, t0);
      repeat (300) @(negedge clk);
      run_a(40, 60, 3, t0);
      chk("t4_count", 32'(q_a.size() - m_a), 3);
      chk_rep("t4_stuck", 1'b0, m_a,     0, 0, 1'b1, 1'b0);
      chk_rep("t4_r1",    1'b0, m_a + 1, 25, 10, 1'b0, 1'b0);
      chk_rep("t4_r2",    1'b0, m_a + 2, 25, 10, 1'b0, 1'b0);

      // 5: reset pulsed mid-high phase
      run_a(40, 60, 2, t0);
      pwm_a = 1'b1;
      repeat (20) @(negedge clk);
      chk("t5_hold_period", 32'(period_a), 25);
      chk("t5_hold_high",   32'(high_a), 10);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_async_period", 32'(period_a), 0);
      chk("t5_async_high",   32'(high_a), 0);
      chk("t5_async_valid",  32'(valid_a), 0);
      chk("t5_async_stuck",  32'(stuck_a), 0);
      chk("t5_async_level",  32'(level_a), 0);
      m_a = q_a.size();
      m_b = q_b.size();
      repeat (20) @(negedge clk);
      pwm_a = 1'b0;
      repeat (20) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      run_a(40, 60, 2, t0);
      repeat (40) @(negedge clk);
      chk("t5_count", 32'(q_a.size() - m_a), 1);
      chk_rep("t5_r0", 1'b0, m_a, 25, 10, 1'b0, 1'b0);
      // dut_b was idle since reset with its line low: one stuck-low report
      chk("t5_b_count", 32'(q_b.size() - m_b), 1);
      chk_rep("t5_b_stuck", 1'b1, m_b, 0, 0, 1'b1, 1'b0);

      // 6: 8-bit, clk/1, TIMEOUT 254, period 300 clk
      m_b = q_b.size();
      run_b(100, 200, 2, t0);
      repeat (100) @(negedge clk);
      chk("t6_count", 32'(q_b.size() - m_b), 2);
      chk_rep("t6_stuck0", 1'b1, m_b,     0, 0, 1'b1, 1'b0);
      chk_rep("t6_stuck1", 1'b1, m_b + 1, 0, 0, 1'b1, 1'b0);
      if (q_b.size() - m_b >= 2) begin
         chk("t6_latency0", 32'(q_b[m_b].cyc - t0), 257);
         chk("t6_latency1", 32'(q_b[m_b + 1].cyc - t0), 557);
      end
      chk("t6_frozen_cnt", 32'(dut_b.per_cnt_q), 254);

      chk("no_double_valid_a", 32'(dbl_a), 0);
      chk("no_double_valid_b", 32'(dbl_b), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
